// File: rtl/dense_pkg.sv
// Shared types, default widths and the output clamp for the dense layer controller.
package dense_pkg;

  localparam int DEF_IP_DATA_WIDTH = 8;
  localparam int DEF_WT_WIDTH      = 8;
  localparam int DEF_NUM_IP        = 8;
  localparam int DEF_NUM_NEURONS   = 2;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, OUT} dense_state_t;

  // Clamp negative to zero and positive overflow to the largest out_w-bit signed value.
  function automatic logic [63:0] relu_sat(input logic signed [63:0] acc, input int out_w);
    logic signed [63:0] max_pos;
    max_pos = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    if (acc < 64'sd0)
      return '0;
    else if (acc > max_pos)
      return max_pos;
    else
      return acc;
  endfunction

endpackage

// File: rtl/dense_mac_unit.sv
// Registered signed multiply-accumulate shared by every neuron of the layer.
module dense_mac_unit
  import dense_pkg::*;
#(
  parameter int A_W   = DEF_IP_DATA_WIDTH,
  parameter int B_W   = DEF_WT_WIDTH,
  parameter int ACC_W = DEF_IP_DATA_WIDTH + DEF_WT_WIDTH + $clog2(DEF_NUM_IP)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [A_W+B_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   acc_q;

  always_comb begin
    prod_p0 = a * b;
    acc_d   = acc_q;
    if (clr)
      acc_d = '0;
    else if (en)
      acc_d = acc_q + ACC_W'(prod_p0);
  end

  // p0 -> accumulator register
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/dense_layer_ctrl.sv
// Buffers one input vector and time-shares a single MAC across all neurons of a dense layer.
module dense_layer_ctrl
  import dense_pkg::*;
#(
  parameter int IP_DATA_WIDTH = DEF_IP_DATA_WIDTH,
  parameter int WT_WIDTH      = DEF_WT_WIDTH,
  parameter int NUM_IP        = DEF_NUM_IP,
  parameter int NUM_NEURONS   = DEF_NUM_NEURONS,
  parameter int ACC_WIDTH     = IP_DATA_WIDTH + WT_WIDTH + $clog2(NUM_IP),
  localparam int OUT_W = IP_DATA_WIDTH + WT_WIDTH,
  localparam int AW    = $clog2(NUM_IP * NUM_NEURONS),
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int K_W   = $clog2(NUM_IP)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [IP_DATA_WIDTH-1:0] in_data,
  output logic                            wt_rd_en,
  output logic [AW-1:0]                   wt_addr,
  input  logic signed [WT_WIDTH-1:0]      wt_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_W-1:0]                out_data,
  output logic [IDX_W-1:0]                out_idx,
  output logic                            busy
);

  dense_state_t state_q, state_d;
  logic [K_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [K_W-1:0]   k_p1_q;
  logic [IDX_W-1:0] n_q, n_d;
  logic             in_ready_q, in_ready_d;
  logic             vld_p1_q;
  logic             acc_clr;
  logic             in_beat;
  logic [K_W-1:0]   wr_idx;
  logic signed [IP_DATA_WIDTH-1:0] x_q [NUM_IP];
  logic signed [IP_DATA_WIDTH-1:0] x_d [NUM_IP];
  logic signed [ACC_WIDTH-1:0]     acc;

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    k_d      = k_q;
    n_d      = n_q;
    acc_clr  = 1'b0;
    x_d      = x_q;
    in_beat  = in_valid && in_ready_q;
    wr_idx   = (state_q == LOAD) ? ld_cnt_q : '0;
    if (in_beat)
      x_d[wr_idx] = in_data;

    case (state_q)
      IDLE: begin
        if (in_beat) begin
          ld_cnt_d = K_W'(1);
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (in_beat) begin
          if (ld_cnt_q == K_W'(NUM_IP - 1)) begin
            ld_cnt_d = '0;
            n_d      = '0;
            k_d      = '0;
            acc_clr  = 1'b1;
            state_d  = MAC;
          end else begin
            ld_cnt_d = ld_cnt_q + K_W'(1);
          end
        end
      end
      MAC: begin
        // k parks on the last index so wt_addr holds while reads are idle
        if (k_q == K_W'(NUM_IP - 1))
          state_d = DRAIN;
        else
          k_d = k_q + K_W'(1);
      end
      DRAIN: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          if (n_q == IDX_W'(NUM_NEURONS - 1)) begin
            state_d = IDLE;
          end else begin
            n_d     = n_q + IDX_W'(1);
            k_d     = '0;
            acc_clr = 1'b1;
            state_d = MAC;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_cnt_q   <= '0;
      k_q        <= '0;
      n_q        <= '0;
      in_ready_q <= 1'b0;
      vld_p1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      k_q        <= k_d;
      n_q        <= n_d;
      in_ready_q <= in_ready_d;
      vld_p1_q   <= (state_q == MAC);
    end
  end

  // p0 -> p1: ROM data returns one cycle after the read, so the operand index follows it
  always_ff @(posedge clk) begin
    x_q    <= x_d;
    k_p1_q <= k_q;
  end

  dense_mac_unit #(
    .A_W  (IP_DATA_WIDTH),
    .B_W  (WT_WIDTH),
    .ACC_W(ACC_WIDTH)
  ) u_mac (
    .clk(clk),
    .clr(rst || acc_clr),
    .en (vld_p1_q),
    .a  (x_q[k_p1_q]),
    .b  (wt_data),
    .acc(acc)
  );

  always_comb begin
    in_ready  = in_ready_q;
    wt_rd_en  = (state_q == MAC);
    wt_addr   = AW'(int'(n_q) * NUM_IP + int'(k_q));
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
    out_data  = '0;
    out_idx   = '0;
    if (state_q == OUT) begin
      out_data = OUT_W'(relu_sat(64'(acc), OUT_W));
      out_idx  = n_q;
    end
  end

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Randomised self-checking bench for dense_layer_ctrl against a plain-arithmetic layer model.
module tb_dense_layer_ctrl;

  localparam int NIP = 8;
  localparam int NN  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic signed [7:0] in_data = '0;
  logic        wt_rd_en;
  logic [3:0]  wt_addr;
  logic signed [7:0] wt_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [0:0]  out_idx;
  logic        busy;

  dense_layer_ctrl #(
    .IP_DATA_WIDTH(8), .WT_WIDTH(8), .NUM_IP(NIP), .NUM_NEURONS(NN)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic signed [7:0] xv  [NIP];
  logic signed [7:0] rom [NIP*NN];

  // Weight ROM: data appears one cycle after the read strobe
  always @(posedge clk) begin
    cyc++;
    if (wt_rd_en) wt_data <= rom[wt_addr];
  end

  int addr_log[$];
  int acyc_log[$];
  always @(negedge clk) begin
    if (wt_rd_en) begin
      addr_log.push_back(int'(wt_addr));
      acyc_log.push_back(cyc);
    end
  end

  int          last_beat_cyc, load_timeout, timeout, bp_bad, rden_bad, inrdy_bad, n_got;
  logic [15:0] got_data [NN];
  int          got_idx  [NN];
  int          got_cyc  [NN];

  function automatic int ref_out(input int n);
    int s = 0;
    for (int i = 0; i < NIP; i++) s += int'(xv[i]) * int'(rom[n*NIP + i]);
    if (s < 0) s = 0;
    if (s > 32767) s = 32767;
    return s;
  endfunction

  // gap: 0 = continuous, 1 = every other cycle, 2 = random
  task automatic load_vector(input int gap);
    int i = 0;
    int g = 0;
    load_timeout = 0;
    while (i < NIP && g < 200) begin
      in_valid = (gap == 0) ? 1'b1 : (gap == 1) ? ((g % 2) == 0) : 1'($urandom_range(0, 1));
      in_data  = xv[i];
      if (in_valid && in_ready) begin
        last_beat_cyc = cyc;
        i++;
      end
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    if (i < NIP) load_timeout = 1;
  endtask

  task automatic drain_outputs(input int bp);
    timeout = 0; bp_bad = 0; rden_bad = 0; inrdy_bad = 0; n_got = 0;
    for (int n = 0; n < NN; n++) begin
      int w;
      w = 0;
      while (!out_valid && w < 100) begin
        if (in_ready) inrdy_bad++;
        @(negedge clk);
        w++;
      end
      if (!out_valid) begin
        timeout = 1;
        return;
      end
      got_data[n] = out_data;
      got_idx[n]  = int'(out_idx);
      got_cyc[n]  = cyc;
      for (int b = 0; b < bp; b++) begin
        out_ready = 1'b0;
        if (in_ready) inrdy_bad++;
        @(negedge clk);
        if (!out_valid || out_data !== got_data[n] || int'(out_idx) != got_idx[n]) bp_bad++;
        if (wt_rd_en) rden_bad++;
      end
      if (in_ready) inrdy_bad++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_got++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    n_checks++; if (wt_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_wt_rd_en: got %0b expected 0", wt_rd_en); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    n_checks++; if (out_idx !== 1'b0) begin n_fail++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < NIP; i++) begin
      xv[i] = 8'(i + 1);
      rom[i] = 8'sd1;
      rom[NIP + i] = -8'sd1;
    end
    load_vector(0);
    drain_outputs(0);
    n_checks++; if (timeout != 0 || n_got != NN) begin n_fail++; $display("FAIL basic_count: got %0d results expected %0d", n_got, NN); end
    n_checks++; if (got_data[0] !== 16'd36 || got_idx[0] != 0) begin n_fail++; $display("FAIL basic_n0: got idx %0d data %0d expected idx 0 data 36", got_idx[0], got_data[0]); end
    n_checks++; if (got_data[1] !== 16'd0 || got_idx[1] != 1) begin n_fail++; $display("FAIL basic_n1: got idx %0d data %0d expected idx 1 data 0", got_idx[1], got_data[1]); end
    n_checks++; if (got_cyc[0] - last_beat_cyc != NIP + 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", got_cyc[0] - last_beat_cyc, NIP + 2); end
    n_checks++; if (got_cyc[1] - got_cyc[0] != NIP + 2) begin n_fail++; $display("FAIL basic_next_latency: got %0d expected %0d", got_cyc[1] - got_cyc[0], NIP + 2); end
  endtask

  task automatic test_input_gaps();
    load_vector(1);
    drain_outputs(0);
    n_checks++; if (load_timeout != 0 || timeout != 0 || n_got != NN) begin n_fail++; $display("FAIL gaps_count: got %0d results expected %0d", n_got, NN); end
    n_checks++; if (got_data[0] !== 16'd36 || got_data[1] !== 16'd0) begin n_fail++; $display("FAIL gaps_data: got %0d,%0d expected 36,0", got_data[0], got_data[1]); end
    n_checks++; if (inrdy_bad != 0) begin n_fail++; $display("FAIL gaps_in_ready_busy: got %0d cycles with in_ready=1 expected 0", inrdy_bad); end
  endtask

  task automatic test_backpressure();
    load_vector(0);
    drain_outputs(5);
    n_checks++; if (timeout != 0 || n_got != NN) begin n_fail++; $display("FAIL bp_count: got %0d results expected %0d", n_got, NN); end
    n_checks++; if (bp_bad != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bp_bad); end
    n_checks++; if (rden_bad != 0) begin n_fail++; $display("FAIL bp_rd_en: got %0d read cycles expected 0", rden_bad); end
    n_checks++; if (got_data[0] !== 16'd36 || got_idx[1] != 1) begin n_fail++; $display("FAIL bp_data: got %0d idx1 %0d expected 36 idx1 1", got_data[0], got_idx[1]); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NIP; i++) begin
      xv[i] = 8'sd127;
      rom[i] = 8'sd127;
      rom[NIP + i] = -8'sd128;
    end
    load_vector(0);
    drain_outputs(0);
    n_checks++; if (timeout != 0 || got_data[0] !== 16'd32767) begin n_fail++; $display("FAIL sat_max: got %0d expected 32767", got_data[0]); end
    n_checks++; if (got_data[1] !== 16'd0) begin n_fail++; $display("FAIL sat_neg: got %0d expected 0", got_data[1]); end
  endtask

  task automatic test_reset_mid_mac();
    int w = 0;
    int stale = 0;
    for (int i = 0; i < NIP; i++) begin
      xv[i] = 8'($urandom_range(0, 255));
      rom[i] = 8'($urandom_range(0, 255));
      rom[NIP + i] = 8'($urandom_range(0, 255));
    end
    load_vector(0);
    while (!(wt_rd_en && wt_addr == 4'd4) && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_checks++; if (!(wt_rd_en && wt_addr == 4'd4)) begin n_fail++; $display("FAIL midrst_reach_k4: got addr %0d expected 4", wt_addr); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({in_ready, wt_rd_en, out_valid, busy} !== 4'b0000 || out_data !== 16'd0 || out_idx !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got rdy %0b rd %0b ov %0b busy %0b data %0d idx %0d expected all 0", in_ready, wt_rd_en, out_valid, busy, out_data, out_idx);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid || busy) stale++;
      @(negedge clk);
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d active cycles expected 0", stale); end
    addr_log.delete();
    acyc_log.delete();
    load_vector(0);
    drain_outputs(0);
    for (int n = 0; n < NN; n++) begin
      n_checks++; if (timeout != 0 || got_data[n] !== 16'(ref_out(n)) || got_idx[n] != n) begin
        n_fail++; $display("FAIL midrst_result%0d: got idx %0d data %0d expected idx %0d data %0d", n, got_idx[n], got_data[n], n, ref_out(n));
      end
    end
  endtask

  task automatic test_addr_sequence();
    int bad = 0;
    n_checks++; if (addr_log.size() != NIP * NN) begin n_fail++; $display("FAIL addr_count: got %0d reads expected %0d", addr_log.size(), NIP * NN); end
    for (int i = 0; i < addr_log.size() && i < NIP * NN; i++) begin
      if (addr_log[i] != i) bad++;
      if ((i % NIP) != 0 && acyc_log[i] != acyc_log[i-1] + 1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL addr_sequence: got %0d bad entries expected 0", bad); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int bp;
      bp = $urandom_range(0, 3);
      for (int i = 0; i < NIP; i++) xv[i] = 8'($urandom_range(0, 255));
      for (int j = 0; j < NIP * NN; j++) rom[j] = 8'($urandom_range(0, 255));
      if (it == 0) for (int i = 0; i < NIP; i++) xv[i] = 8'($urandom_range(0, 127));
      load_vector(2);
      drain_outputs(bp);
      n_checks++; if (load_timeout != 0 || timeout != 0 || n_got != NN) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", it, n_got, NN); end
      for (int n = 0; n < NN; n++) begin
        n_checks++; if (got_data[n] !== 16'(ref_out(n)) || got_idx[n] != n) begin
          n_fail++; $display("FAIL rand%0d_n%0d: got idx %0d data %0d expected idx %0d data %0d", it, n, got_idx[n], got_data[n], n, ref_out(n));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_input_gaps();
    test_backpressure();
    test_saturation();
    test_reset_mid_mac();
    test_addr_sequence();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
